// File: rtl/otter_rf_pkg.sv
// Shared defaults and helpers for the OTTER register file with pending-write scoreboard.
// Optional write-to-read bypass is enabled with the REG_FILE_BYPASS_EN macro.
package otter_rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned NRD_DEF   = 2;
    localparam int unsigned CNT_W_DEF = 2;

    // Address width for a register array of n entries (at least 1 bit)
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [NRD_DEF-1:0][XLEN_DEF-1:0] rd_bus_t;

endpackage

// File: rtl/otter_rf_scoreboard.sv
// Per-register pending-write counters; reports nonzero/saturated (and, with
// REG_FILE_BYPASS_EN, exactly-one) status per register.
module otter_rf_scoreboard
    import otter_rf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    localparam int unsigned AW   = addr_w(NREGS)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             issue_en_i,
    input  logic [AW-1:0]    issue_addr_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic             flush_i,
    input  logic             issue_acc_i,
    output logic [NREGS-1:0] cnt_nz_o,
`ifdef REG_FILE_BYPASS_EN
    output logic [NREGS-1:0] cnt_one_o,
`endif
    output logic [NREGS-1:0] cnt_sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];

    // Same-register issue and writeback cancel; writeback never underflows
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush_i) begin
                cnt_d[r] = '0;
            end else begin
                if (issue_acc_i && issue_addr_i == AW'(r)) begin
                    if (!(wr_en_i && wr_addr_i == AW'(r)))
                        cnt_d[r] = cnt_q[r] + CNT_W'(1);
                end else if (wr_en_i && wr_addr_i == AW'(r) && r != 0
                             && cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_nz_o[r]  = (cnt_q[r] != '0);
            cnt_sat_o[r] = (cnt_q[r] == CNT_MAX);
`ifdef REG_FILE_BYPASS_EN
            cnt_one_o[r] = (cnt_q[r] == CNT_W'(1));
`endif
        end
    end

    logic unused_issue_en;
    assign unused_issue_en = issue_en_i;

endmodule

// File: rtl/otter_reg_file_sb.sv
// OTTER integer register file with pending-write scoreboard and async reads.
// Define REG_FILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module otter_reg_file_sb
    import otter_rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = NRD_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    localparam int unsigned AW   = addr_w(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                issue_en_i,
    input  logic [AW-1:0]       issue_addr_i,
    output logic                issue_ready_o,
    input  logic                flush_i
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] cnt_nz;
    logic [NREGS-1:0] cnt_sat;
    logic             issue_acc;
    logic             wr_hit;

    assign wr_hit        = wr_en_i && (wr_addr_i != '0);
    assign issue_acc     = issue_en_i && (issue_addr_i != '0) && !cnt_sat[issue_addr_i];
    assign issue_ready_o = !(issue_en_i && (issue_addr_i != '0) && cnt_sat[issue_addr_i]);

`ifdef REG_FILE_BYPASS_EN
    logic [NREGS-1:0] cnt_one;
`endif

    otter_rf_scoreboard #(
        .NREGS (NREGS),
        .CNT_W (CNT_W)
    ) u_sb (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .issue_en_i   (issue_en_i),
        .issue_addr_i (issue_addr_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .flush_i      (flush_i),
        .issue_acc_i  (issue_acc),
        .cnt_nz_o     (cnt_nz),
`ifdef REG_FILE_BYPASS_EN
        .cnt_one_o    (cnt_one),
`endif
        .cnt_sat_o    (cnt_sat)
    );

    // Register 0 is never written, so it holds its reset value of zero
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else if (wr_hit) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rd_addr_i[i*AW +: AW];

        always_comb begin
            rd_data_o[i*XLEN +: XLEN] = regs_q[ra];
            rd_busy_o[i]              = (ra != '0) && cnt_nz[ra];
`ifdef REG_FILE_BYPASS_EN
            if (wr_hit && wr_addr_i == ra) begin
                rd_data_o[i*XLEN +: XLEN] = wr_data_i;
                if (cnt_one[ra]) rd_busy_o[i] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_otter_reg_file_sb.sv
// Directed self-checking bench for otter_reg_file_sb (default parameters).
module tb_otter_reg_file_sb;

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NRD  = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                issue_en;
    logic [AW-1:0]       issue_addr;
    logic                issue_ready;
    logic                flush;

    int n_checks = 0;
    int n_fail   = 0;

    otter_reg_file_sb dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_busy_o     (rd_busy),
        .issue_en_i    (issue_en),
        .issue_addr_i  (issue_addr),
        .issue_ready_o (issue_ready),
        .flush_i       (flush)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic do_issue(input logic [AW-1:0] a);
        issue_en = 1'b1; issue_addr = a;
        tick();
    endtask

    task automatic do_wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
        set_rd(5'd5, 5'd7);
        n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_rd_busy got %b want 00", rd_busy); end
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready got %b want 1", issue_ready); end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write;
        do_wb(5'd5, 32'hDEADBEEF);
        do_wb(5'd0, 32'h0000_1234);
        set_rd(5'd5, 5'd0);
        n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_x5 got %h want deadbeef", rd_data[31:0]); end
        n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL write_x0 got %h want 0", rd_data[63:32]); end
    endtask

    task automatic test_issue_saturate;
        set_rd(5'd7, 5'd0);
        for (int k = 0; k < 3; k++) begin
            issue_en = 1'b1; issue_addr = 5'd7; #1;
            n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready_%0d got %b want 1", k, issue_ready); end
            tick();
        end
        issue_en = 1'b1; issue_addr = 5'd7; #1;
        n_checks++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL issue_sat got %b want 0", issue_ready); end
        issue_addr = 5'd0; #1;
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL issue_x0_ready got %b want 1", issue_ready); end
        issue_addr = 5'd7;
        tick();
        for (int k = 0; k < 3; k++) begin
            do_wb(5'd7, 32'h70 + 32'(k));
            n_checks++;
            if (rd_busy[0] !== (k < 2)) begin n_fail++; $display("FAIL wb_x7_busy_%0d got %b want %b", k, rd_busy[0], k < 2); end
        end
        n_checks++; if (rd_data[31:0] !== 32'h72) begin n_fail++; $display("FAIL wb_x7_data got %h want 72", rd_data[31:0]); end
    endtask

    task automatic test_same_cycle;
        set_rd(5'd9, 5'd0);
        do_issue(5'd9);
        issue_en = 1'b1; issue_addr = 5'd9;
        do_wb(5'd9, 32'h99);
        n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL same_cycle_busy got %b want 1", rd_busy[0]); end
        n_checks++; if (rd_data[31:0] !== 32'h99) begin n_fail++; $display("FAIL same_cycle_data got %h want 99", rd_data[31:0]); end
        do_wb(5'd9, 32'h9A);
        n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL same_cycle_drain got %b want 0", rd_busy[0]); end
    endtask

    task automatic test_flush;
        do_issue(5'd3);
        do_issue(5'd4);
        do_issue(5'd10);
        set_rd(5'd3, 5'd4);
        n_checks++; if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL pre_flush_busy got %b want 11", rd_busy); end
        flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd10;
        do_wb(5'd3, 32'h55);
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL flush_busy_3_4 got %b want 00", rd_busy); end
        n_checks++; if (rd_data[31:0] !== 32'h55) begin n_fail++; $display("FAIL flush_x3_data got %h want 55", rd_data[31:0]); end
        set_rd(5'd10, 5'd3);
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL flush_busy_10 got %b want 00", rd_busy); end
    endtask

    task automatic test_bypass;
        do_wb(5'd12, 32'h1111);
        do_issue(5'd12);
        set_rd(5'd12, 5'd12);
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hA5A5; #1;
`ifdef REG_FILE_BYPASS_EN
        n_checks++; if (rd_data !== {32'hA5A5, 32'hA5A5}) begin n_fail++; $display("FAIL bypass_data got %h want a5a5 x2", rd_data); end
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL bypass_busy got %b want 00", rd_busy); end
`else
        n_checks++; if (rd_data !== {32'h1111, 32'h1111}) begin n_fail++; $display("FAIL nobypass_data got %h want 1111 x2", rd_data); end
        n_checks++; if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL nobypass_busy got %b want 11", rd_busy); end
`endif
        tick();
        n_checks++; if (rd_data !== {32'hA5A5, 32'hA5A5}) begin n_fail++; $display("FAIL post_wb_data got %h want a5a5 x2", rd_data); end
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL post_wb_busy got %b want 00", rd_busy); end
    endtask

    task automatic test_underflow;
        set_rd(5'd15, 5'd0);
        do_wb(5'd15, 32'hF0);
        n_checks++; if (rd_data[31:0] !== 32'hF0) begin n_fail++; $display("FAIL uf_data got %h want f0", rd_data[31:0]); end
        n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL uf_busy got %b want 0", rd_busy[0]); end
        // A wrapped counter would read saturated after one more issue
        do_issue(5'd15);
        do_issue(5'd15);
        issue_en = 1'b1; issue_addr = 5'd15; #1;
        n_checks++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL uf_ready got %b want 1", issue_ready); end
        issue_en = 1'b0; #1;
    endtask

    task automatic test_reset_mid;
        do_issue(5'd20);
        set_rd(5'd5, 5'd20);
        n_checks++; if (rd_busy !== 2'b10) begin n_fail++; $display("FAIL pre_rst_busy got %b want 10", rd_busy); end
        @(negedge clk); rst_n = 1'b0; #1;
        n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL mid_rst_data got %h want 0", rd_data); end
        n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL mid_rst_busy got %b want 00", rd_busy); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_issue_saturate();
        test_same_cycle();
        test_flush();
        test_bypass();
        test_underflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/otter_reg_file_sb.md
# otter_reg_file_sb

Parametrised integer register file for the pipelined OTTER with an integrated per-register pending-write scoreboard and optional write-to-read bypass. Provides NRD asynchronous read ports plus one synchronous write port. Tracks in-flight writes between decode issue and writeback so the hazard unit can stall on RD_BUSY. It sits in the decode stage; the writeback stage drives the write port.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥ 2); register 0 is hardwired zero
- NRD, 2, number of read ports (1–4)
- CNT_W, 2, width of each per-register pending-write counter
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- WR_EN  in  1  writeback valid
- WR_ADDR  in  $clog2(NREGS)  writeback destination
- WR_DATA  in  XLEN  writeback data
- RD_ADDR  in  NRD×$clog2(NREGS)  read addresses, packed, port 0 in LSBs
- RD_DATA  out  NRD×XLEN  read data, packed
- RD_BUSY  out  NRD  read register has an outstanding write whose value is not available this cycle
- ISSUE_EN  in  1  decode issues an instruction that will write ISSUE_ADDR
- ISSUE_ADDR  in  $clog2(NREGS)  destination of the issued instruction
- ISSUE_READY  out  1  issue accepted this cycle
- FLUSH  in  1  discard all pending-write tracking (branch mispredict)

## Operation
- Reset (RST_N low, asynchronous): all registers 0, all counters 0. During reset RD_DATA = 0, RD_BUSY = 0, ISSUE_READY = 1.
- Write: on rising edge with WR_EN and WR_ADDR ≠ 0, register[WR_ADDR] ← WR_DATA. WR_ADDR = 0 is ignored. Register 0 always reads 0.
- Read: RD_DATA[i] = register[RD_ADDR[i]], combinational.
- Scoreboard: each register r ≠ 0 has a counter cnt[r] of CNT_W bits.
  - An issue is accepted when ISSUE_EN, ISSUE_ADDR ≠ 0 and cnt[ISSUE_ADDR] < 2^CNT_W − 1.
  - ISSUE_READY = 0 only when ISSUE_EN and cnt[ISSUE_ADDR] is saturated. ISSUE_ADDR = 0 is always ready and never counted.
  - An accepted issue increments cnt[ISSUE_ADDR]. WR_EN with WR_ADDR ≠ 0 and cnt ≠ 0 decrements cnt[WR_ADDR]. A writeback to a register with cnt = 0 updates data and leaves the counter unchanged (no underflow).
  - Issue and writeback to the same register in the same cycle: counter unchanged.
  - FLUSH clears all counters at the clock edge and has priority over a same-cycle issue or writeback count. The register data write still occurs.
- RD_BUSY[i] = (RD_ADDR[i] ≠ 0) && cnt[RD_ADDR[i]] ≠ 0, modified by the bypass rule below.

## Timing
- Read latency 0 cycles (combinational from RD_ADDR and state).
- Write latency 1 cycle: without bypass, data written at edge N is visible on RD_DATA after edge N.
- Counter updates are visible on RD_BUSY/ISSUE_READY the cycle after the edge.
- ISSUE_READY is combinational from ISSUE_EN/ISSUE_ADDR and counters. It does not depend on same-cycle WR_EN.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - When WR_EN && WR_ADDR ≠ 0 && WR_ADDR == RD_ADDR[i], RD_DATA[i] = WR_DATA in the same cycle.
  - RD_BUSY[i] is additionally forced 0 when that match holds and cnt[RD_ADDR[i]] == 1 (the last pending write is landing now).
- Undefined: no forwarding path. RD_DATA comes from register state only, and RD_BUSY is the raw counter test.

## Structure
- Package otter_rf_pkg: default XLEN/NREGS/NRD/CNT_W localparams, the address-width function, and the typedef for the packed read-port bundle.
- Sub-module otter_rf_scoreboard: holds the counter array and produces cnt-nonzero and cnt-saturated vectors. Inputs are the issue, writeback and FLUSH controls. The top level holds the data array, read muxes and bypass.

## Test plan
- Reset, then write 0xDEADBEEF to x5 and 0x1234 to x0 → x5 reads 0xDEADBEEF after the edge; x0 reads 0; assert RST_N mid-run → all reads 0, RD_BUSY = 0.
- Issue x7 three times (CNT_W = 2) → ISSUE_READY = 1, 1, 1, then 0 on a fourth attempt; three writebacks to x7 → RD_BUSY[0] for x7 drops after the third edge.
- Same cycle issue x9 and writeback x9 with cnt = 1 → cnt stays 1, RD_BUSY stays 1.
- Pending on x3, x4, x10, then FLUSH with a writeback to x3 of 0x55 → all RD_BUSY = 0 next cycle and x3 = 0x55.
- With REG_FILE_BYPASS_EN, cnt[x12] = 1 and writeback 0xA5A5 to x12 while both ports read x12 → both RD_DATA = 0xA5A5 and RD_BUSY = 0 in the same cycle. Without the macro → old value, RD_BUSY = 1.
- Writeback to x15 with cnt = 0 → data updated, counter remains 0, no underflow.
